// File: rtl/sti_dac_param.sv
// sti_dac_param
// Parametrised serial transmitter with an output-memory byte packer.
// A parallel word is shaped into an F-bit frame (F = 8*(pi_length+1)),
// shifted out one bit per cycle, and the bit stream is packed into bytes
// that are written round-robin across NUM_BANKS interleaved memories.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   load         frame request, taken when pi_ready=1
//   pi_data      parallel payload (IN_W bits)
//   pi_length    frame length code, F = 8*(pi_length+1)
//   pi_fill      F > IN_W: payload in MSBs, zeros below
//   pi_sext      F > IN_W, pi_fill=0: sign- (1) or zero- (0) extend
//   pi_msb       1: MSB first, 0: LSB first
//   pi_low       F < IN_W: 1 takes the top F bits, 0 the bottom F bits
//   pi_end       marks the accepted frame as the last one
//   pi_ready     load is accepted this cycle
//   so_data      serial bit (0 when so_valid=0)
//   so_valid     so_data valid
//   oem_dataout  packed byte
//   oem_addr     per-bank write address
//   oem_wr       one-hot bank write strobe
//   oem_finish   sticky, all data of the end frame written
module sti_dac_param #(
    parameter int IN_W      = 16,
    parameter int LEN_W     = 2,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [IN_W-1:0]      pi_data,
    input  logic [LEN_W-1:0]     pi_length,
    input  logic                 pi_fill,
    input  logic                 pi_sext,
    input  logic                 pi_msb,
    input  logic                 pi_low,
    input  logic                 pi_end,
    output logic                 pi_ready,
    output logic                 so_data,
    output logic                 so_valid,
    output logic [7:0]           oem_dataout,
    output logic [ADDR_W-1:0]    oem_addr,
    output logic [NUM_BANKS-1:0] oem_wr,
    output logic                 oem_finish
);
    localparam int MAXF   = 8 * (2 ** LEN_W);
    localparam int EW     = (MAXF > IN_W) ? MAXF : IN_W;
    localparam int CNT_W  = LEN_W + 3;
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int BC_W   = ADDR_W + BANK_W;

    typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [MAXF-1:0]       r_frame;
    logic [CNT_W-1:0]      r_bitcnt;
    logic [CNT_W-1:0]      r_flast;
    logic                  r_msb;
    logic                  r_end;
    logic [2:0]            r_bitin;
    logic [6:0]            r_byte;
    logic [BC_W-1:0]       r_bytecnt;
    logic [NUM_BANKS-1:0]  r_wr;
    logic [7:0]            r_dout;
    logic [ADDR_W-1:0]     r_addr;

    logic                  w_last;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_idx;
    logic [MAXF-1:0]       w_word;

    // Frame word, right-aligned in the low F bits of the frame register.
    function automatic logic [MAXF-1:0] build_word(
        input logic [IN_W-1:0]  data,
        input logic [LEN_W-1:0] len,
        input logic             fill,
        input logic             sext,
        input logic             low
    );
        int                     f;
        logic signed [IN_W-1:0] sdata;
        logic [EW-1:0]          zx;
        logic [EW-1:0]          sx;
        logic [EW-1:0]          mask;
        logic [EW-1:0]          word;
        f     = 8 * (int'(len) + 1);
        sdata = $signed(data);
        zx    = EW'(data);
        sx    = EW'(sdata);
        // wraps to all ones when f == EW
        mask  = (EW'(1) << f) - EW'(1);
        if (f == IN_W)
            word = zx;
        else if (f < IN_W)
            word = low ? (zx >> (IN_W - f)) : (zx & mask);
        else if (fill)
            word = zx << (f - IN_W);
        else if (sext)
            word = sx & mask;
        else
            word = zx;
        return word[MAXF-1:0];
    endfunction

    assign w_word   = build_word(pi_data, pi_length, pi_fill, pi_sext, pi_low);
    assign w_last   = (r_state == SEND) && (r_bitcnt == r_flast);
    assign pi_ready = (r_state == IDLE) || w_last;
    assign w_accept = load && pi_ready;
    assign w_idx    = r_msb ? (r_flast - r_bitcnt) : r_bitcnt;
    assign so_valid = (r_state == SEND);
    assign so_data  = so_valid && r_frame[w_idx];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SEND;
            SEND:    if (w_last && !w_accept) w_state_nxt = r_end ? FINISH : IDLE;
            FINISH:  w_state_nxt = FINISH;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Frame capture and bit sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitcnt <= '0;
            r_flast  <= '0;
            r_msb    <= 1'b0;
            r_end    <= 1'b0;
        end else if (w_accept) begin
            r_bitcnt <= '0;
            r_flast  <= {pi_length, 3'b111};   // F-1
            r_msb    <= pi_msb;
            r_end    <= pi_end;
        end else if (so_valid) begin
            r_bitcnt <= r_bitcnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_frame <= w_word;
    end

    // Byte packer: the 8th bit is taken straight from so_data, so only
    // seven earlier bits need storing; a reset clears r_bitin, which is
    // enough to discard any partial byte.
    always_ff @(posedge clk) begin
        if (so_valid) r_byte <= {r_byte[5:0], so_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitin   <= '0;
            r_bytecnt <= '0;
            r_wr      <= '0;
            r_dout    <= '0;
            r_addr    <= '0;
        end else begin
            r_wr <= '0;
            if (so_valid) begin
                r_bitin <= r_bitin + 3'd1;
                if (r_bitin == 3'd7) begin
                    r_dout    <= {r_byte, so_data};
                    r_addr    <= r_bytecnt[BC_W-1 -: ADDR_W];
                    r_wr      <= NUM_BANKS'(1) << r_bytecnt[BANK_W-1:0];
                    r_bytecnt <= r_bytecnt + BC_W'(1);
                end
            end
        end
    end

    assign oem_dataout = r_dout;
    assign oem_addr    = r_addr;
    assign oem_wr      = r_wr;
    // The last write of the end frame lands on the same edge the FSM
    // enters FINISH, and FINISH is left only by reset.
    assign oem_finish  = (r_state == FINISH);

endmodule

// File: tb/tb_sti_dac_param.sv
module tb_sti_dac_param;
    logic        clk = 1'b0;
    logic        reset, load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill, pi_sext, pi_msb, pi_low, pi_end;

    logic        pi_ready, so_data, so_valid, oem_finish;
    logic [7:0]  oem_dataout;
    logic [4:0]  oem_addr;
    logic [3:0]  oem_wr;

    logic        b_pi_ready, b_so_data, b_so_valid, b_oem_finish;
    logic [7:0]  b_oem_dataout;
    logic [0:0]  b_oem_addr;
    logic [3:0]  b_oem_wr;

    int checks = 0;
    int errors = 0;

    logic       a_bit_q[$];
    logic [7:0] a_data_q[$];
    int         a_bank_q[$];
    int         a_addr_q[$];
    logic [7:0] b_data_q[$];
    int         b_bank_q[$];
    int         b_addr_q[$];

    always #5 clk = ~clk;

    sti_dac_param #(.IN_W(16), .LEN_W(2), .NUM_BANKS(4), .ADDR_W(5)) u_dut (
        .clk(clk), .reset(reset), .load(load), .pi_data(pi_data), .pi_length(pi_length),
        .pi_fill(pi_fill), .pi_sext(pi_sext), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .pi_ready(pi_ready), .so_data(so_data), .so_valid(so_valid), .oem_dataout(oem_dataout),
        .oem_addr(oem_addr), .oem_wr(oem_wr), .oem_finish(oem_finish)
    );

    sti_dac_param #(.IN_W(16), .LEN_W(2), .NUM_BANKS(4), .ADDR_W(1)) u_dut_w (
        .clk(clk), .reset(reset), .load(load), .pi_data(pi_data), .pi_length(pi_length),
        .pi_fill(pi_fill), .pi_sext(pi_sext), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .pi_ready(b_pi_ready), .so_data(b_so_data), .so_valid(b_so_valid), .oem_dataout(b_oem_dataout),
        .oem_addr(b_oem_addr), .oem_wr(b_oem_wr), .oem_finish(b_oem_finish)
    );

    function automatic int onehot_idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v == (4'b0001 << i)) r = i;
        return r;
    endfunction

    // Record serial bits and memory writes away from the active edge.
    always @(negedge clk) begin
        if (so_valid === 1'b1) a_bit_q.push_back(so_data);
        if (oem_wr !== 4'b0000) begin
            a_data_q.push_back(oem_dataout);
            a_bank_q.push_back(onehot_idx(oem_wr));
            a_addr_q.push_back(int'(oem_addr));
        end
        if (b_oem_wr !== 4'b0000) begin
            b_data_q.push_back(b_oem_dataout);
            b_bank_q.push_back(onehot_idx(b_oem_wr));
            b_addr_q.push_back(int'(b_oem_addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load_frame(input logic [15:0] d, input logic [1:0] len, input logic fill,
                              input logic sext, input logic msb, input logic low, input logic e);
        pi_data = d; pi_length = len; pi_fill = fill; pi_sext = sext;
        pi_msb = msb; pi_low = low; pi_end = e;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (so_valid === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (so_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout so_valid=%b expected 0 within 100 cycles", tag, so_valid);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (pi_ready !== 1'b1) begin errors++; $display("FAIL reset_pi_ready got %b exp 1", pi_ready); end
        checks++; if (so_valid !== 1'b0) begin errors++; $display("FAIL reset_so_valid got %b exp 0", so_valid); end
        checks++; if (so_data !== 1'b0) begin errors++; $display("FAIL reset_so_data got %b exp 0", so_data); end
        checks++; if (oem_wr !== 4'b0000) begin errors++; $display("FAIL reset_oem_wr got %b exp 0000", oem_wr); end
        checks++; if (oem_dataout !== 8'h00) begin errors++; $display("FAIL reset_dataout got %h exp 00", oem_dataout); end
        checks++; if (oem_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", oem_addr); end
        checks++; if (oem_finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b exp 0", oem_finish); end
        reset = 1'b0;
    endtask

    task automatic test_msb8();
        logic [7:0] exp_b = 8'hA5;
        int wb;
        do_reset();
        wb = a_data_q.size();
        load_frame(16'hA55A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({so_valid, so_data} !== {1'b1, exp_b[7-i]}) begin
                errors++;
                $display("FAIL msb8_bit%0d got valid=%b data=%b exp valid=1 data=%b", i, so_valid, so_data, exp_b[7-i]);
            end
            tick();
        end
        checks++;
        if (oem_wr !== 4'b0001 || oem_addr !== 5'd0 || oem_dataout !== 8'hA5 || so_valid !== 1'b0) begin
            errors++;
            $display("FAIL msb8_write got wr=%b addr=%0d data=%h valid=%b exp wr=0001 addr=0 data=a5 valid=0",
                     oem_wr, oem_addr, oem_dataout, so_valid);
        end
        // low segment of the same payload
        load_frame(16'hA55A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done("low8");
        checks++;
        if (a_data_q.size() != wb + 2) begin
            errors++; $display("FAIL low8_count got %0d exp %0d", a_data_q.size() - wb, 2);
        end else if (a_data_q[wb+1] !== 8'h5A || a_bank_q[wb+1] != 1 || a_addr_q[wb+1] != 0) begin
            errors++;
            $display("FAIL low8_write got data=%h bank=%0d addr=%0d exp data=5a bank=1 addr=0",
                     a_data_q[wb+1], a_bank_q[wb+1], a_addr_q[wb+1]);
        end
    endtask

    task automatic test_fill_lsb();
        logic [23:0] got;
        logic [7:0]  ed [3] = '{8'h00, 8'h2C, 8'h48};
        int bb, wb;
        do_reset();
        bb = a_bit_q.size();
        wb = a_data_q.size();
        load_frame(16'h1234, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done("fill");
        checks++;
        if (a_bit_q.size() != bb + 24) begin
            errors++; $display("FAIL fill_bitcount got %0d exp 24", a_bit_q.size() - bb);
        end else begin
            got = '0;
            for (int i = 0; i < 24; i++) got[i] = a_bit_q[bb+i];
            if (got !== 24'h123400) begin
                errors++; $display("FAIL fill_bits got %h exp 123400", got);
            end
        end
        checks++;
        if (a_data_q.size() != wb + 3) begin
            errors++; $display("FAIL fill_wrcount got %0d exp 3", a_data_q.size() - wb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (a_data_q[wb+i] !== ed[i] || a_bank_q[wb+i] != i || a_addr_q[wb+i] != 0) begin
                    errors++;
                    $display("FAIL fill_byte%0d got data=%h bank=%0d addr=%0d exp data=%h bank=%0d addr=0",
                             i, a_data_q[wb+i], a_bank_q[wb+i], a_addr_q[wb+i], ed[i], i);
                end
            end
        end
    endtask

    task automatic test_sext();
        logic [7:0] ed [8] = '{8'hFF, 8'hFF, 8'h80, 8'h01, 8'h00, 8'h00, 8'h80, 8'h01};
        int wb;
        do_reset();
        wb = a_data_q.size();
        load_frame(16'h8001, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_done("sext1");
        load_frame(16'h8001, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done("sext0");
        checks++;
        if (a_data_q.size() != wb + 8) begin
            errors++; $display("FAIL sext_wrcount got %0d exp 8", a_data_q.size() - wb);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (a_data_q[wb+i] !== ed[i] || a_bank_q[wb+i] != i % 4 || a_addr_q[wb+i] != i / 4) begin
                    errors++;
                    $display("FAIL sext_byte%0d got data=%h bank=%0d addr=%0d exp data=%h bank=%0d addr=%0d",
                             i, a_data_q[wb+i], a_bank_q[wb+i], a_addr_q[wb+i], ed[i], i % 4, i / 4);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ed [4] = '{8'hBE, 8'hEF, 8'hC0, 8'hDE};
        int wb, vcnt, ign;
        do_reset();
        wb = a_data_q.size();
        pi_data = 16'hBEEF; pi_length = 2'd1; pi_fill = 1'b0; pi_sext = 1'b0;
        pi_msb = 1'b1; pi_low = 1'b0; pi_end = 1'b0;
        load = 1'b1;
        tick();
        // next frame's inputs presented while the first is in flight
        pi_data = 16'hC0DE; pi_end = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (so_valid === 1'b1) vcnt++;
            if (i == 16) load = 1'b0;
            if (i == 31) begin
                checks++;
                if (oem_finish !== 1'b0) begin errors++; $display("FAIL b2b_finish_early got %b exp 0", oem_finish); end
            end
            tick();
        end
        checks++;
        if (vcnt != 32) begin errors++; $display("FAIL b2b_valid_cycles got %0d exp 32", vcnt); end
        checks++;
        if (so_valid !== 1'b0 || oem_finish !== 1'b1 || oem_wr !== 4'b1000 || oem_dataout !== 8'hDE || pi_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got valid=%b finish=%b wr=%b data=%h ready=%b exp 0 1 1000 de 0",
                     so_valid, oem_finish, oem_wr, oem_dataout, pi_ready);
        end
        load = 1'b1;
        pi_data = 16'h5555; pi_end = 1'b0;
        ign = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (so_valid !== 1'b0 || oem_finish !== 1'b1) ign++;
        end
        load = 1'b0;
        tick();
        checks++;
        if (ign != 0) begin errors++; $display("FAIL b2b_finish_hold got %0d bad cycles exp 0", ign); end
        checks++;
        if (a_data_q.size() != wb + 4) begin
            errors++; $display("FAIL b2b_wrcount got %0d exp 4", a_data_q.size() - wb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (a_data_q[wb+i] !== ed[i] || a_bank_q[wb+i] != i || a_addr_q[wb+i] != 0) begin
                    errors++;
                    $display("FAIL b2b_byte%0d got data=%h bank=%0d addr=%0d exp data=%h bank=%0d addr=0",
                             i, a_data_q[wb+i], a_bank_q[wb+i], a_addr_q[wb+i], ed[i], i);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ed [9] = '{8'h00, 8'h00, 8'h13, 8'h57, 8'h24, 8'h68, 8'h00, 8'h00, 8'hBC};
        int wa, wbb, bb;
        do_reset();
        wa  = a_data_q.size();
        wbb = b_data_q.size();
        bb  = a_bit_q.size();
        load_frame(16'h1357, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        // a request in mid-frame must be dropped
        pi_data = 16'hFFFF; pi_length = 2'd0; pi_end = 1'b1; load = 1'b1;
        tick();
        tick();
        load = 1'b0;
        wait_done("wrap_a");
        load_frame(16'h2468, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done("wrap_b");
        load_frame(16'h9ABC, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done("wrap_c");
        checks++;
        if (a_bit_q.size() != bb + 72) begin errors++; $display("FAIL wrap_bitcount got %0d exp 72", a_bit_q.size() - bb); end
        checks++;
        if (oem_finish !== 1'b0 || pi_ready !== 1'b1) begin
            errors++; $display("FAIL wrap_idle got finish=%b ready=%b exp 0 1", oem_finish, pi_ready);
        end
        checks++;
        if (b_data_q.size() != wbb + 9) begin
            errors++; $display("FAIL wrap_wrcount got %0d exp 9", b_data_q.size() - wbb);
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (b_data_q[wbb+i] !== ed[i] || b_bank_q[wbb+i] != i % 4 || b_addr_q[wbb+i] != (i / 4) % 2) begin
                    errors++;
                    $display("FAIL wrap_byte%0d got data=%h bank=%0d addr=%0d exp data=%h bank=%0d addr=%0d",
                             i, b_data_q[wbb+i], b_bank_q[wbb+i], b_addr_q[wbb+i], ed[i], i % 4, (i / 4) % 2);
                end
            end
        end
        checks++;
        if (a_data_q.size() != wa + 9) begin
            errors++; $display("FAIL wrap_wide_count got %0d exp 9", a_data_q.size() - wa);
        end else if (a_bank_q[wa+8] != 0 || a_addr_q[wa+8] != 2) begin
            errors++; $display("FAIL wrap_wide_ninth got bank=%0d addr=%0d exp bank=0 addr=2", a_bank_q[wa+8], a_addr_q[wa+8]);
        end
    endtask

    task automatic test_reset_mid();
        int wb;
        do_reset();
        wb = a_data_q.size();
        load_frame(16'hFFFF, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (so_valid !== 1'b1) begin errors++; $display("FAIL rstmid_sending got valid=%b exp 1", so_valid); end
        reset = 1'b1;
        tick();
        checks++;
        if (so_valid !== 1'b0 || oem_wr !== 4'b0000 || pi_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_abort got valid=%b wr=%b ready=%b exp 0 0000 1", so_valid, oem_wr, pi_ready);
        end
        reset = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (a_data_q.size() != wb) begin errors++; $display("FAIL rstmid_partial got %0d writes exp 0", a_data_q.size() - wb); end
        load_frame(16'h003C, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done("rstmid_next");
        checks++;
        if (a_data_q.size() != wb + 1) begin
            errors++; $display("FAIL rstmid_next_count got %0d exp 1", a_data_q.size() - wb);
        end else if (a_data_q[wb] !== 8'h3C || a_bank_q[wb] != 0 || a_addr_q[wb] != 0) begin
            errors++;
            $display("FAIL rstmid_next got data=%h bank=%0d addr=%0d exp data=3c bank=0 addr=0",
                     a_data_q[wb], a_bank_q[wb], a_addr_q[wb]);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; pi_data = '0; pi_length = '0;
        pi_fill = 1'b0; pi_sext = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
        test_reset();
        test_msb8();
        test_fill_lsb();
        test_sext();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
